i2c_master_arbiter: RTL and testbench

//  Shares one i2c_master engine between NREQ local requesters; one single-byte transaction per grant.

---
 rtl/i2c_arb_pkg.sv | 11 +
 rtl/i2c_rr_pick.sv | 28 ++
 rtl/i2c_master_arbiter.sv | 130 +++++++++++++
 tb/tb_i2c_master_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared types and default sizes for the i2c master arbiter.
package i2c_arb_pkg;
  typedef enum logic [2:0] {
    IDLE, WAIT_ACCEPT, WAIT_DONE, COMPLETE, RECOVER
  } arb_state_t;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_ADDR_W  = 7;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_TIMEOUT = 4096;
endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module i2c_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [PW-1:0]   idx,
  output logic            any
);
  // Scan from the farthest offset down so the closest hit to ptr is written last.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int i = NREQ-1; i >= 0; i--) begin
      automatic int j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) begin
        onehot    = '0;
        onehot[j] = 1'b1;
        idx       = PW'(j);
        any       = 1'b1;
      end
    end
  end
endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one i2c_master engine among NREQ requesters, one byte per grant, round-robin.
module i2c_master_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  input  logic [NREQ-1:0]          req_rw,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic [NREQ-1:0]          err,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     busy,
  input  logic                     lines_busy,
  input  logic                     m_ready,
  input  logic [DATA_W-1:0]        m_data_out,
  output logic                     m_enable,
  output logic [ADDR_W-1:0]        m_addr,
  output logic [DATA_W-1:0]        m_data_in,
  output logic                     m_rw
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT+1);

  arb_state_t      state;
  logic [PW-1:0]   ptr, w_idx, pick_idx;
  logic [NREQ-1:0] pick_oh;
  logic            pick_any;
  logic [CW-1:0]   cnt;
  logic            cnt_exp;
  logic [PW-1:0]   ptr_next;

  i2c_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign cnt_exp  = (cnt == CW'(TIMEOUT-1));
  assign ptr_next = (int'(w_idx) == NREQ-1) ? '0 : w_idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      w_idx     <= '0;
      cnt       <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= '0;
      rd_data   <= '0;
      busy      <= 1'b0;
      m_enable  <= 1'b0;
      m_addr    <= '0;
      m_data_in <= '0;
      m_rw      <= 1'b0;
    end else begin
      done <= '0;
      err  <= '0;
      case (state)
        IDLE: begin
          if (pick_any && m_ready && !lines_busy) begin
            gnt       <= pick_oh;
            w_idx     <= pick_idx;
            m_enable  <= 1'b1;
            m_addr    <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
            m_data_in <= req_data[int'(pick_idx)*DATA_W +: DATA_W];
            m_rw      <= req_rw[pick_idx];
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= WAIT_ACCEPT;
          end
        end
        WAIT_ACCEPT: begin
          cnt <= cnt + 1'b1;
          if (cnt_exp) begin
            m_enable   <= 1'b0;
            gnt        <= '0;
            err[w_idx] <= 1'b1;
            ptr        <= ptr_next;
            state      <= RECOVER;
          end else if (!m_ready) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          cnt <= cnt + 1'b1;
          // A ready rise beats a coincident timeout.
          if (m_ready) begin
            m_enable    <= 1'b0;
            gnt         <= '0;
            done[w_idx] <= 1'b1;
            ptr         <= ptr_next;
            if (m_rw) rd_data <= m_data_out;
            state       <= COMPLETE;
          end else if (cnt_exp) begin
            m_enable   <= 1'b0;
            gnt        <= '0;
            err[w_idx] <= 1'b1;
            ptr        <= ptr_next;
            state      <= RECOVER;
          end
        end
        COMPLETE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        RECOVER: begin
          if (m_ready) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter; the i2c_master ready handshake is driven by hand.
module tb_i2c_master_arbiter;
  localparam int NREQ = 4, AW = 7, DW = 8, TO = 16;

  logic              clk, rst;
  logic [NREQ-1:0]   req, req_rw;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   gnt, done, err;
  logic [DW-1:0]     rd_data, m_data_out, m_data_in;
  logic              busy, lines_busy, m_ready, m_enable, m_rw;
  logic [AW-1:0]     m_addr;

  int tests = 0, fails = 0;

  i2c_master_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .req_rw(req_rw), .gnt(gnt), .done(done), .err(err), .rd_data(rd_data),
    .busy(busy), .lines_busy(lines_busy), .m_ready(m_ready), .m_data_out(m_data_out),
    .m_enable(m_enable), .m_addr(m_addr), .m_data_in(m_data_in), .m_rw(m_rw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for launch, check payload, run ready 1->0->1, check done pulse.
  task automatic txn(input string tag, input logic [NREQ-1:0] eg, input logic [AW-1:0] ea,
                     input logic [DW-1:0] ed, input logic erw, input logic [DW-1:0] rdb,
                     input int elat);
    int n = 0;
    do begin @(negedge clk); n++; end while (!m_enable && n < 100);
    chk({tag, ".lat"}, n, elat);
    chk({tag, ".gnt"}, gnt, eg);
    chk({tag, ".addr"}, m_addr, ea);
    chk({tag, ".data"}, m_data_in, ed);
    chk({tag, ".rw"}, m_rw, erw);
    chk({tag, ".busy"}, busy, 1);
    m_ready = 1'b0;
    @(negedge clk);
    chk({tag, ".nodone"}, done, 0);
    @(negedge clk);
    m_data_out = rdb;
    m_ready = 1'b1;
    @(negedge clk);
    chk({tag, ".done"}, done, eg);
    chk({tag, ".noerr"}, err, 0);
    chk({tag, ".en_off"}, m_enable, 0);
    chk({tag, ".gnt_off"}, gnt, 0);
    if (erw) chk({tag, ".rd"}, rd_data, rdb);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic ok;
    rst = 1'b1; req = '0; req_rw = '0; req_addr = '0; req_data = '0;
    lines_busy = 1'b0; m_ready = 1'b1; m_data_out = '0;
    req_addr[0*AW +: AW] = 7'h01; req_data[0*DW +: DW] = 8'hCD;
    req_addr[1*AW +: AW] = 7'h22; req_data[1*DW +: DW] = 8'h11;
    req_addr[2*AW +: AW] = 7'h33; req_data[2*DW +: DW] = 8'h44;
    req_addr[3*AW +: AW] = 7'h50; req_data[3*DW +: DW] = 8'h99;
    repeat (3) @(negedge clk);
    chk("rst.gnt", gnt, 0);
    chk("rst.en", m_enable, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.err", err, 0);
    chk("rst.rd", rd_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // T1 single write from requester 0
    req = 4'b0001;
    txn("t1", 4'b0001, 7'h01, 8'hCD, 1'b0, 8'h00, 1);
    req = 4'b0000;
    @(negedge clk);
    chk("t1.pulse", done, 0);
    chk("t1.idle", busy, 0);

    // T2 two writers held: order 0,1,0 from a fresh pointer
    do_reset();
    req = 4'b0011;
    txn("t2a", 4'b0001, 7'h01, 8'hCD, 1'b0, 8'h00, 1);
    txn("t2b", 4'b0010, 7'h22, 8'h11, 1'b0, 8'h00, 2);
    txn("t2c", 4'b0001, 7'h01, 8'hCD, 1'b0, 8'h00, 2);
    req = 4'b0000;
    @(negedge clk);

    // T3 launch deferred while another master holds the bus
    lines_busy = 1'b1;
    req = 4'b0100;
    ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (m_enable !== 1'b0 || gnt !== 4'b0000) ok = 1'b0;
    end
    chk("t3.held", ok, 1);
    lines_busy = 1'b0;
    txn("t3", 4'b0100, 7'h33, 8'h44, 1'b0, 8'h00, 1);
    req = 4'b0000;
    @(negedge clk);

    // T4 read from requester 3, then a write must not disturb rd_data
    req_rw = 4'b1000;
    req = 4'b1000;
    txn("t4", 4'b1000, 7'h50, 8'h99, 1'b1, 8'h55, 1);
    req = 4'b0000; req_rw = 4'b0000;
    @(negedge clk);
    req = 4'b0001;
    txn("t4w", 4'b0001, 7'h01, 8'hCD, 1'b0, 8'hAA, 1);
    req = 4'b0000;
    chk("t4.hold", rd_data, 8'h55);
    @(negedge clk);

    // T5 engine never returns ready: err after TIMEOUT cycles, then RECOVER
    req = 4'b0001;
    @(negedge clk);
    chk("t5.launch", m_enable, 1);
    m_ready = 1'b0;
    ok = 1'b1;
    for (int k = 1; k < TO; k++) begin
      @(negedge clk);
      if (err !== 4'b0000 || done !== 4'b0000 || m_enable !== 1'b1) ok = 1'b0;
    end
    chk("t5.wait", ok, 1);
    @(negedge clk);
    chk("t5.err", err, 4'b0001);
    chk("t5.nodone", done, 0);
    chk("t5.en", m_enable, 0);
    chk("t5.gnt", gnt, 0);
    req = 4'b0000;
    repeat (3) @(negedge clk);
    chk("t5.errclr", err, 0);
    chk("t5.recover", busy, 1);
    m_ready = 1'b1;
    @(negedge clk);
    chk("t5.idle", busy, 0);

    // T6 async reset during WAIT_DONE; pointer returns to 0
    req = 4'b0011;
    @(negedge clk);
    chk("t6.gnt1", gnt, 4'b0010);
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6.en", m_enable, 0);
    chk("t6.gnt", gnt, 0);
    chk("t6.busy", busy, 0);
    @(negedge clk);
    chk("t6.nodone", done, 0);
    chk("t6.noerr", err, 0);
    m_ready = 1'b1;
    rst = 1'b0;
    txn("t6", 4'b0001, 7'h01, 8'hCD, 1'b0, 8'h00, 1);
    req = 4'b0000;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
